// File: rtl/zoom_pkg.sv
// Shared constants, FSM state encoding and output beat layout for the zoom frame streamer.
package zoom_pkg;

    localparam int unsigned DEF_BASE_ADDR = 8192;
    localparam int unsigned DEF_WIDTH     = 100;
    localparam int unsigned DEF_HEIGHT    = 100;
    localparam int unsigned PIX_W         = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } tag_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } beat_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry valid/ready buffer for output beats; an incoming beat falls straight
// through to the output when the buffer is empty, otherwise it is queued.
module pix_skid_fifo
    import zoom_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  beat_t      in_beat,
    output logic       out_valid,
    input  logic       out_ready,
    output beat_t      out_beat,
    output logic [1:0] level
);

    beat_t      store_q [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       empty;
    logic       store;
    logic       pop;

    assign empty     = (count == 2'd0);
    assign out_valid = !empty || in_valid;
    assign out_beat  = !empty ? store_q[rd_ptr] : (in_valid ? in_beat : '0);
    // Bypass only when nothing is queued and the sink takes the beat this cycle.
    assign store     = in_valid && !(empty && out_ready);
    assign pop       = !empty && out_ready;
    assign level     = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            store_q[0] <= '0;
            store_q[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (store) begin
                store_q[wr_ptr] <= in_beat;
                wr_ptr          <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + 2'(store) - 2'(pop);
        end
    end

endmodule

// File: rtl/zoom_frame_streamer.sv
// Scans the zoomed frame out of dmem row-major and streams it on a valid/ready bus
// with sof/eol/eof markers. Optional running checksum under `FRAME_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start; row/col counters parked at 0
// RUN   | issuing dmem reads whenever the output path has room
// DRAIN | all reads issued, waiting for the eof beat to be accepted
// DONE  | one-cycle done pulse, then back to IDLE
module zoom_frame_streamer
    import zoom_pkg::*;
#(
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned HEIGHT    = DEF_HEIGHT,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [31:0]       frame_csum
`endif
);

    localparam int unsigned       CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned       RW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0]     COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] next_addr;
    tag_t              iss_tag;
    tag_t              pend_tag;
    logic              rd_pend;

    beat_t             in_beat;
    beat_t             out_beat;
    logic [1:0]        level;
    logic [2:0]        occ;
    logic              hs;
    logic              room;
    logic              accept_start;
    logic              issue;
    logic              last_rd;

    assign hs           = pix_valid && pix_ready;
    // Occupancy after this edge plus the read whose data lands next cycle; a new
    // read is only issued if it is guaranteed a slot even if the sink stalls.
    assign occ          = 3'(level) + 3'(rd_pend) + 3'(mem_rd_en) - 3'(hs);
    assign room         = (occ < 3'd2);
    assign accept_start = (state == IDLE) && start;
    assign issue        = accept_start || ((state == RUN) && room);
    assign last_rd      = (col == COL_LAST) && (row == ROW_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= BASE;
            next_addr <= BASE;
            col       <= '0;
            row       <= '0;
            iss_tag   <= '0;
            pend_tag  <= '0;
            rd_pend   <= 1'b0;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= issue;
            rd_pend   <= mem_rd_en;
            pend_tag  <= iss_tag;

            if (issue) begin
                mem_addr    <= next_addr;
                iss_tag.sof <= (row == '0) && (col == '0);
                iss_tag.eol <= (col == COL_LAST);
                iss_tag.eof <= last_rd;
                if (last_rd) begin
                    col       <= '0;
                    row       <= '0;
                    next_addr <= BASE;
                end else begin
                    next_addr <= next_addr + 1'b1;
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= last_rd ? DRAIN : RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue && last_rd) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs && pix_eof) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_beat.data = mem_rd_data;
    assign in_beat.sof  = pend_tag.sof;
    assign in_beat.eol  = pend_tag.eol;
    assign in_beat.eof  = pend_tag.eof;

    pix_skid_fifo u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_pend),
        .in_beat   (in_beat),
        .out_valid (pix_valid),
        .out_ready (pix_ready),
        .out_beat  (out_beat),
        .level     (level)
    );

    assign pix_data = out_beat.data;
    assign pix_sof  = out_beat.sof;
    assign pix_eol  = out_beat.eol;
    assign pix_eof  = out_beat.eof;

`ifdef FRAME_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_csum <= '0;
        end else if (accept_start) begin
            frame_csum <= '0;
        end else if (hs) begin
            frame_csum <= frame_csum + 32'(pix_data);
        end
    end
`endif

endmodule

// File: tb/tb_zoom_frame_streamer.sv
// Self-checking bench for zoom_frame_streamer: table of whole-frame scenarios plus
// reset-in-idle and reset-mid-frame sequences, checked against a beat scoreboard.
module tb_zoom_frame_streamer;
    import zoom_pkg::*;

    localparam int BASE = 8192;
    localparam int W    = 100;
    localparam int H    = 100;
    localparam int N    = W * H;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, mem_rd_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [7:0]  pix_data;
    logic        pix_sof, pix_eol, pix_eof;
`ifdef FRAME_CHECKSUM_EN
    logic [31:0] frame_csum;
`endif

    zoom_frame_streamer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .pix_eof     (pix_eof)
`ifdef FRAME_CHECKSUM_EN
        ,
        .frame_csum  (frame_csum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // dmem model: registered read, data valid the cycle after mem_rd_en
    logic [7:0] dmem [N];
    int         rd_idx;
    always @(posedge clk) begin
        if (mem_rd_en) begin
            rd_idx = int'(mem_addr) - BASE;
            mem_rd_data <= (rd_idx >= 0 && rd_idx < N) ? dmem[rd_idx] : 8'h00;
        end
    end

    int ready_pct = 100;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // scoreboard and monitor
    logic [10:0] sb [$];
    logic [31:0] model_sum;
    int exp_addr, issued, accepted, max_out;
    int first_valid_cyc, eof_cyc, done_cyc, done_cnt;
    bit stall_pend = 1'b0;
    logic [10:0] held, got, e;

    always @(negedge clk) begin
        if (reset_n) begin
            got = {pix_data, pix_sof, pix_eol, pix_eof};
            if (mem_rd_en) begin
                chk(mem_addr == 32'(exp_addr), "rd_addr", longint'(mem_addr), longint'(exp_addr));
                exp_addr++;
                issued++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (stall_pend)
                chk(pix_valid && got == held, "stall_hold", longint'({pix_valid, got}), longint'({1'b1, held}));
            if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pix_valid && pix_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "extra_beat", longint'(got), 0);
                end else begin
                    e = sb.pop_front();
                    chk(got == e, "beat", longint'(got), longint'(e));
                end
                accepted++;
                if (pix_eof) eof_cyc = cyc;
            end
            stall_pend = pix_valid && !pix_ready;
            held = got;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int pattern);
        for (int i = 0; i < N; i++)
            dmem[i] = (pattern == 0) ? 8'(i) : (pattern == 1) ? 8'h01 : 8'hFF;
    endtask

    task automatic push_frame();
        sb.delete();
        model_sum = 32'h0;
        for (int i = 0; i < N; i++) begin
            sb.push_back({dmem[i], i == 0, (i % W) == W - 1, i == N - 1});
            model_sum = model_sum + 32'(dmem[i]);
        end
    endtask

    task automatic reset_mon();
        exp_addr = BASE;
        issued = 0;
        accepted = 0;
        max_out = 0;
        first_valid_cyc = -1;
        eof_cyc = -1;
        done_cyc = -1;
        done_cnt = 0;
    endtask

    typedef struct {
        int          pattern;
        int          ready_pct;
        bit          inject;
        logic [31:0] csum;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int  start_cyc;
        bit  seen, inj;
        fill(v.pattern);
        push_frame();
        reset_mon();
        ready_pct = v.ready_pct;
        chk(busy == 1'b0, "idle_busy", longint'(busy), 0);
        start_cyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk(busy == 1'b1, "busy_after_start", longint'(busy), 1);
        seen = 1'b0;
        inj = 1'b0;
        for (int k = 0; k < 40000; k++) begin
            tick();
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                if (v.inject) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                break;
            end
            if (v.inject && !inj && accepted >= 300) begin
                start = 1'b1;
                inj = 1'b1;
            end
        end
        chk(seen, "done_timeout", longint'(seen), 1);
        repeat (20) tick();
        chk(accepted == N, "beat_count", accepted, N);
        chk(sb.size() == 0, "sb_empty", sb.size(), 0);
        chk(issued == N, "read_count", issued, N);
        chk(done_cnt == 1, "done_pulses", done_cnt, 1);
        // start sampled at the next edge: issue cycle, data-return cycle with valid
        chk(first_valid_cyc == start_cyc + 2, "first_valid_lat", first_valid_cyc - start_cyc, 2);
        chk(done_cyc == eof_cyc + 1, "done_after_eof", done_cyc - eof_cyc, 1);
        chk(max_out <= 2, "outstanding", max_out, 2);
        chk(busy == 1'b0, "busy_after_done", longint'(busy), 0);
        if (v.ready_pct == 100)
            chk(done_cyc - start_cyc <= 10003, "frame_cycles", done_cyc - start_cyc, 10003);
`ifdef FRAME_CHECKSUM_EN
        chk(frame_csum == model_sum, "csum_model", longint'(frame_csum), longint'(model_sum));
        chk(frame_csum == v.csum, "csum_table", longint'(frame_csum), longint'(v.csum));
`endif
    endtask

    vec_t vecs[4];

    initial begin
        bit ok;
        int sc;
        vecs[0] = '{pattern: 0, ready_pct: 100, inject: 1'b1, csum: 32'h0013_6CF8};
        vecs[1] = '{pattern: 0, ready_pct: 50,  inject: 1'b0, csum: 32'h0013_6CF8};
        vecs[2] = '{pattern: 1, ready_pct: 100, inject: 1'b0, csum: 32'h0000_2710};
        vecs[3] = '{pattern: 2, ready_pct: 100, inject: 1'b0, csum: 32'h0026_E8F0};
        reset_mon();

        repeat (3) @(posedge clk);
        #1;
        chk({busy, done, mem_rd_en, pix_valid, pix_sof, pix_eol, pix_eof} == 7'b0, "reset_outputs",
            longint'({busy, done, mem_rd_en, pix_valid, pix_sof, pix_eol, pix_eof}), 0);
        chk(mem_addr == 32'(BASE), "reset_addr", longint'(mem_addr), BASE);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) run_frame(vecs[v]);

        // reset while idle, then 100 cycles without start
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk({busy, done, mem_rd_en, pix_valid, pix_sof, pix_eol, pix_eof} == 7'b0, "idle_reset_outputs",
            longint'({busy, done, mem_rd_en, pix_valid, pix_sof, pix_eol, pix_eof}), 0);
        chk(mem_addr == 32'(BASE), "idle_reset_addr", longint'(mem_addr), BASE);
        tick();
        reset_n = 1'b1;
        reset_mon();
        repeat (100) tick();
        chk(issued == 0, "idle_no_read", issued, 0);

        // reset in the middle of a frame, then restart from the top
        ready_pct = 100;
        fill(0);
        push_frame();
        reset_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (accepted >= 500) begin
                ok = 1'b1;
                break;
            end
        end
        chk(ok, "mid_frame_progress", accepted, 500);
        reset_n = 1'b0;
        #1;
        chk({pix_valid, busy, mem_rd_en} == 3'b0, "mid_frame_reset", longint'({pix_valid, busy, mem_rd_en}), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        push_frame();
        reset_mon();
        sc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (accepted >= 600) begin
                ok = 1'b1;
                break;
            end
        end
        chk(ok, "restart_progress", accepted, 600);
        chk(first_valid_cyc == sc + 2, "restart_latency", first_valid_cyc - sc, 2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
